// File: rtl/psum_accum_pkg.sv
// Shared encodings for the psum accumulate memory: request opcodes and clear FSM states.
package psum_accum_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_ACCUM = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SWEEP = 2'b10,
        ST_DONE  = 2'b11
    } clr_state_e;

endpackage

// File: rtl/psum_sat_add.sv
// One lane of signed saturating add; the extra sign bit detects overflow.
module psum_sat_add #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] a,
    input  logic [psum_bw-1:0] b,
    output logic [psum_bw-1:0] y
);

    logic [psum_bw:0] sum;

    // widen both operands by sign extension, add, clamp if the top two bits disagree
    always_comb begin
        sum = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (sum[psum_bw] != sum[psum_bw-1]) begin
            y = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
            y = sum[psum_bw-1:0];
        end
    end

endmodule

// File: rtl/psum_accum_mem.sv
// Output psum memory: raw write, per-lane saturating accumulate, read with optional
// ReLU, and a bulk zero sweep driven by a small clear FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting requests, waiting for clear_start
// ST_DRAIN | requests blocked, waiting for the in-flight write to land
// ST_SWEEP | writing zero to one word per cycle, counter 0..DEPTH-1
// ST_DONE  | single cycle, clear_done pulse
module psum_accum_mem
    import psum_accum_pkg::*;
#(
    parameter int psum_bw    = 16,
    parameter int col        = 8,
    parameter int addr_width = 11,
    parameter int DEPTH      = 1 << addr_width
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic [addr_width-1:0]     req_addr,
    input  logic [psum_bw*col-1:0]    req_data,
    input  logic                      req_relu,
    output logic                      rd_valid,
    output logic [psum_bw*col-1:0]    rd_data,
    input  logic                      clear_start,
    output logic                      clear_busy,
    output logic                      clear_done
);

    localparam int W = psum_bw * col;
    localparam logic [addr_width:0]   DEPTH_EXT = (addr_width + 1)'(DEPTH);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];

    clr_state_e state, state_nxt;
    logic [addr_width-1:0] clr_cnt;

    logic                  s1_valid;
    op_e                   s1_op;
    logic [addr_width-1:0] s1_addr;
    logic [W-1:0]          s1_data;
    logic                  s1_relu;
    logic                  s1_inrange;
    logic [W-1:0]          s1_old;

    logic         accept;
    logic         req_inrange;
    logic         s1_wr;
    logic         fwd_hit;
    logic         s1_rd;
    logic [W-1:0] acc_word;
    logic [W-1:0] new_word;
    logic [W-1:0] relu_word;

    assign accept      = req_valid & req_ready;
    assign req_inrange = ({1'b0, req_addr} < DEPTH_EXT);
    assign s1_wr       = s1_valid & s1_inrange & ((s1_op == OP_WRITE) | (s1_op == OP_ACCUM));
    assign s1_rd       = s1_valid & (s1_op == OP_READ);
    // the word being written this edge is newer than what the array returns for the same address
    assign fwd_hit     = s1_wr & (s1_addr == req_addr);

    for (genvar i = 0; i < col; i++) begin : g_lane
        psum_sat_add #(.psum_bw(psum_bw)) u_sat_add (
            .a (s1_old [psum_bw*i +: psum_bw]),
            .b (s1_data[psum_bw*i +: psum_bw]),
            .y (acc_word[psum_bw*i +: psum_bw])
        );
    end

    assign new_word = (s1_op == OP_ACCUM) ? acc_word : s1_data;

    // ReLU only shapes the returned data, never the stored word
    always_comb begin
        relu_word = s1_old;
        if (s1_relu) begin
            for (int i = 0; i < col; i++) begin
                if (s1_old[psum_bw*i + psum_bw - 1]) begin
                    relu_word[psum_bw*i +: psum_bw] = '0;
                end
            end
        end
    end

    // stage 1 capture with forwarding, stage 2 read response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_op      <= OP_NOP;
            s1_addr    <= '0;
            s1_data    <= '0;
            s1_relu    <= 1'b0;
            s1_inrange <= 1'b0;
            s1_old     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op      <= op_e'(req_op);
                s1_addr    <= req_addr;
                s1_data    <= req_data;
                s1_relu    <= req_relu;
                s1_inrange <= req_inrange;
                if (!req_inrange) begin
                    s1_old <= '0;
                end else if (fwd_hit) begin
                    s1_old <= new_word;
                end else begin
                    s1_old <= mem[req_addr];
                end
            end
            rd_valid <= s1_rd;
            if (s1_rd) begin
                rd_data <= relu_word;
            end
        end
    end

    // single array write port: the sweep only runs once the pipeline is empty
    always_ff @(posedge clk) begin
        if (state == ST_SWEEP) begin
            mem[clr_cnt] <= '0;
        end else if (s1_wr) begin
            mem[s1_addr] <= new_word;
        end
    end

    // clear FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sweep address counter, zeroed while draining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            clr_cnt <= '0;
        end else if (state == ST_SWEEP) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // clear FSM next state and outputs
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        clear_busy = 1'b1;
        clear_done = 1'b0;
        case (state)
            ST_IDLE: begin
                clear_busy = 1'b0;
                req_ready  = reset;
                if (clear_start) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid) begin
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                clear_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_psum_accum_mem.sv
// Scoreboard bench for psum_accum_mem: a bench-side array model predicts every read.
module tb_psum_accum_mem;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int AW      = 11;
    localparam int DEPTH   = 1 << AW;
    localparam int W       = PSUM_BW * COL;

    localparam logic [1:0] OPW = 2'b00;
    localparam logic [1:0] OPA = 2'b01;
    localparam logic [1:0] OPR = 2'b10;
    localparam logic [1:0] OPN = 2'b11;

    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t data;
        int    cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    word_t         req_data;
    logic          req_relu;
    logic          rd_valid;
    word_t         rd_data;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    done_cnt = 0;
    word_t model [DEPTH];
    exp_t  sb [$];

    psum_accum_mem #(
        .psum_bw(PSUM_BW), .col(COL), .addr_width(AW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_relu(req_relu),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t fill(input logic [15:0] v);
        word_t r;
        for (int i = 0; i < COL; i++) r[PSUM_BW*i +: PSUM_BW] = v;
        return r;
    endfunction

    function automatic word_t acc_model(input word_t o, input word_t d);
        word_t r;
        int    s;
        for (int i = 0; i < COL; i++) begin
            s = int'($signed(o[PSUM_BW*i +: PSUM_BW])) + int'($signed(d[PSUM_BW*i +: PSUM_BW]));
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            r[PSUM_BW*i +: PSUM_BW] = 16'(s);
        end
        return r;
    endfunction

    function automatic word_t relu_model(input word_t o);
        word_t r;
        r = o;
        for (int i = 0; i < COL; i++) begin
            if (o[PSUM_BW*i + PSUM_BW - 1]) r[PSUM_BW*i +: PSUM_BW] = '0;
        end
        return r;
    endfunction

    // drive one request just after a falling edge; it is taken at the next rising edge
    task automatic issue(input logic [1:0] op, input int addr, input word_t data, input logic relu);
        int   waits;
        exp_t e;
        waits = 0;
        if (!req_ready) begin
            req_valid = 1'b0;
            while (!req_ready && waits < 50) begin
                @(negedge clk);
                waits++;
            end
            if (!req_ready) chk("ready_wait", 0, 1);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = AW'(addr);
        req_data  = data;
        req_relu  = relu;
        case (op)
            OPW: model[addr] = data;
            OPA: model[addr] = acc_model(model[addr], data);
            OPR: begin
                e.data = relu ? relu_model(model[addr]) : model[addr];
                e.cyc  = cyc + 2;
                sb.push_back(e);
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // response monitor: every rd_valid pulse must match the oldest predicted read
    always @(negedge clk) begin
        exp_t e;
        if (clear_done) done_cnt++;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                chk("rd_extra", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_lat", cyc, e.cyc);
            end
        end
    end

    initial begin
        word_t d;
        int    busy_cnt;
        int    ready_bad;
        int    n;
        int    done_before;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = OPN;
        req_addr    = '0;
        req_data    = '0;
        req_relu    = 1'b0;
        clear_start = 1'b0;

        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", req_ready, 1);
        @(negedge clk);

        // basic write then read
        issue(OPW, 5, fill(16'h0003), 1'b0);
        issue(OPR, 5, '0, 1'b0);
        idle(4);

        // back-to-back accumulate chain exercises forwarding
        issue(OPW, 7, '0, 1'b0);
        issue(OPA, 7, fill(16'h0002), 1'b0);
        issue(OPA, 7, fill(16'h0002), 1'b0);
        issue(OPA, 7, fill(16'h0002), 1'b0);
        issue(OPR, 7, '0, 1'b0);
        idle(4);
        chk("accum_chain", model[7], fill(16'h0006));

        // saturation at both ends; other lanes just add
        d = fill(16'h0100);
        d[15:0]  = 16'h7FF0;
        d[31:16] = 16'h8005;
        issue(OPW, 9, d, 1'b0);
        d = fill(16'h0001);
        d[15:0]  = 16'h0020;
        d[31:16] = 16'hFFF0;
        issue(OPA, 9, d, 1'b0);
        issue(OPR, 9, '0, 1'b0);
        idle(4);

        // ReLU is read-only shaping
        for (int i = 0; i < COL; i++) d[PSUM_BW*i +: PSUM_BW] = (i % 2 == 0) ? 16'hFFFB : 16'h0005;
        issue(OPW, 11, d, 1'b0);
        issue(OPR, 11, '0, 1'b1);
        issue(OPR, 11, '0, 1'b0);
        idle(4);

        // mixed random traffic on a few addresses, including NOPs
        for (int a = 20; a < 24; a++) issue(OPW, a, fill(16'(a)), 1'b0);
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < COL; i++) d[PSUM_BW*i +: PSUM_BW] = 16'($urandom_range(0, 65535));
            issue(2'($urandom_range(0, 3)), 20 + $urandom_range(0, 3), d, 1'($urandom_range(0, 1)));
        end
        idle(4);

        // clear with two requests in flight
        issue(OPW, 0, fill(16'h1111), 1'b0);
        issue(OPW, DEPTH - 1, fill(16'h2222), 1'b0);
        issue(OPR, 5, '0, 1'b0);
        clear_start = 1'b1;
        issue(OPW, 30, fill(16'h3333), 1'b0);
        clear_start = 1'b0;
        req_valid   = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        done_before = done_cnt;
        busy_cnt  = 0;
        ready_bad = 0;
        n = 0;
        while (clear_busy && n < 3000) begin
            busy_cnt++;
            if (req_ready) ready_bad++;
            @(negedge clk);
            n++;
        end
        chk("clr_timeout", (n < 3000) ? 1 : 0, 1);
        // two drain cycles (pending write lands, then empty is seen), DEPTH sweep cycles, one done cycle
        chk("clr_busy_len", busy_cnt, DEPTH + 3);
        chk("clr_ready_low", ready_bad, 0);
        chk("clr_done_once", done_cnt - done_before, 1);
        issue(OPR, 0, '0, 1'b0);
        issue(OPR, 5, '0, 1'b0);
        issue(OPR, DEPTH - 1, '0, 1'b0);
        issue(OPR, 30, '0, 1'b0);
        idle(4);

        // reset in the middle of a sweep
        issue(OPW, 50, fill(16'h1234), 1'b0);
        issue(OPW, 200, fill(16'h0BAD), 1'b0);
        idle(3);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (103) @(negedge clk);
        chk("mid_busy", clear_busy, 1);
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", clear_busy, 0);
        chk("mid_rst_done", clear_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_busy", clear_busy, 0);
        repeat (5) @(negedge clk);
        chk("mid_no_done", done_cnt - done_before, 0);
        model[50] = '0;
        issue(OPR, 50, '0, 1'b0);
        issue(OPR, 200, '0, 1'b0);
        idle(1);

        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
